// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three handshake groups around the memory port arbiter:
//   fetch port  : if_req_i, if_addr_i, if_flush_i -> if_done_o, if_rdata_o, if_err_o
//   data port   : mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_strb_i
//                 -> mem_done_o, mem_rdata_o, mem_err_o
//   shared bus  : bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o
//                 <- bus_ready_i, bus_rsp_valid_i, bus_rdata_i, bus_err_i
// Signal suffixes are from the arbiter's point of view.
// Modports:
//   slave  : the arbiter itself
//   master : the environment (pipeline fetch/data stages and the bus)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
   // fetch port
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_flush_i;
   logic        if_done_o;
   logic [31:0] if_rdata_o;
   logic        if_err_o;
   // data port
   logic        mem_req_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_strb_i;
   logic        mem_done_o;
   logic [31:0] mem_rdata_o;
   logic        mem_err_o;
   // shared bus
   logic        bus_valid_o;
   logic        bus_ready_i;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_strb_o;
   logic        bus_rsp_valid_i;
   logic [31:0] bus_rdata_i;
   logic        bus_err_i;

   modport slave (
      input  if_req_i, if_addr_i, if_flush_i,
      output if_done_o, if_rdata_o, if_err_o,
      input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_strb_i,
      output mem_done_o, mem_rdata_o, mem_err_o,
      output bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o,
      input  bus_ready_i, bus_rsp_valid_i, bus_rdata_i, bus_err_i
   );

   modport master (
      output if_req_i, if_addr_i, if_flush_i,
      input  if_done_o, if_rdata_o, if_err_o,
      output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_strb_i,
      input  mem_done_o, mem_rdata_o, mem_err_o,
      input  bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o,
      output bus_ready_i, bus_rsp_valid_i, bus_rdata_i, bus_err_i
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-outstanding memory bus between an instruction-fetch port
// and a data (load/store) port. The data port has fixed priority. A fetch may
// be discarded by if_flush_i; the bus transaction still completes, but its
// result is never reported to the fetch port.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : synchronous reset, active high
//   port   : mem_port_arbiter_if.slave (fetch, data and bus handshakes)
// -----------------------------------------------------------------------------
module mem_port_arbiter (
   input  logic               clk_i,
   input  logic               rst_i,
   mem_port_arbiter_if.slave  port
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   state_t      r_state;
   state_t      w_next_state;
   owner_t      r_owner;
   logic        r_drop;

   logic        w_grant_mem;
   logic        w_grant_if;
   logic        w_if_done;

   // latched request
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [3:0]  r_bus_strb;

   // response staging and per-port result registers
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_if_rdata;
   logic        r_if_err;
   logic [31:0] r_mem_rdata;
   logic        r_mem_err;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: reset is synchronous here, so it is tested inside the clocked branch
   // rather than listed in the sensitivity list.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: clocked state always uses <= so every flop samples the same
         // pre-edge values regardless of statement order.
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: defaults first so every path assigns every signal; otherwise the
      // tool infers latches.
      w_next_state = r_state;
      w_grant_mem  = 1'b0;
      w_grant_if   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (port.mem_req_i) begin
               w_grant_mem  = 1'b1;
               w_next_state = ST_REQ;
            end else if (port.if_req_i && !port.if_flush_i) begin
               w_grant_if   = 1'b1;
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (port.bus_ready_i) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            // responses arriving in any other state are simply not looked at
            if (port.bus_rsp_valid_i) begin
               w_next_state = ST_DONE;
            end
         end
         // DONE never grants: a requester still holding req during its own
         // done cycle must not get a second transaction
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // a fetch completion is withheld if it was flushed earlier (r_drop) or
      // is being flushed in the done cycle itself
      w_if_done = (r_state == ST_DONE) && (r_owner == OWN_IF) &&
                  !r_drop && !port.if_flush_i;

      port.bus_valid_o = (r_state == ST_REQ);
      port.bus_we_o    = r_bus_we;
      port.bus_addr_o  = r_bus_addr;
      port.bus_wdata_o = r_bus_wdata;
      port.bus_strb_o  = r_bus_strb;

      port.if_done_o   = w_if_done;
      // the fresh response is shown only when it is actually delivered, so a
      // suppressed fetch leaves the visible data untouched
      port.if_rdata_o  = w_if_done ? r_rsp_rdata : r_if_rdata;
      port.if_err_o    = w_if_done ? r_rsp_err   : r_if_err;

      port.mem_done_o  = (r_state == ST_DONE) && (r_owner == OWN_MEM);
      port.mem_rdata_o = r_mem_rdata;
      port.mem_err_o   = r_mem_err;
   end

   // ---------------------------------------------------------------------------
   // Request latch, drop flag and response capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_owner     <= OWN_IF;
         r_drop      <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_strb  <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_if_rdata  <= '0;
         r_if_err    <= 1'b0;
         r_mem_rdata <= '0;
         r_mem_err   <= 1'b0;
      end else begin
         if (w_grant_mem) begin
            r_owner     <= OWN_MEM;
            r_bus_we    <= port.mem_we_i;
            r_bus_addr  <= port.mem_addr_i;
            r_bus_wdata <= port.mem_wdata_i;
            r_bus_strb  <= port.mem_strb_i;
         end else if (w_grant_if) begin
            r_owner     <= OWN_IF;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= port.if_addr_i;
            r_bus_wdata <= '0;
            r_bus_strb  <= 4'hF;
         end

         // a flushed fetch keeps running on the bus; only its result is lost
         if (r_state == ST_DONE) begin
            r_drop <= 1'b0;
         end else if ((r_state == ST_REQ || r_state == ST_RESP) &&
                      r_owner == OWN_IF && port.if_flush_i) begin
            r_drop <= 1'b1;
         end

         if (r_state == ST_RESP && port.bus_rsp_valid_i) begin
            r_rsp_rdata <= port.bus_rdata_i;
            r_rsp_err   <= port.bus_err_i;
            if (r_owner == OWN_MEM) begin
               r_mem_rdata <= port.bus_rdata_i;
               r_mem_err   <= port.bus_err_i;
            end
         end

         // fetch result becomes the held value only once delivered
         if (w_if_done) begin
            r_if_rdata <= r_rsp_rdata;
            r_if_err   <= r_rsp_err;
         end
      end
   end

endmodule
